// File: rtl/scan_sequencer.sv
// Galvo raster scan sequencer: walks (x, block, y) point indices and times the
// DAC write, camera trigger and acquisition window for every point.
module scan_sequencer #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  input  logic [PW-1:0] cfg_x_points,
  input  logic [PW-1:0] cfg_x_blocks,
  input  logic [PW-1:0] cfg_y_points,
  input  logic [PW-1:0] cfg_cycles_per_point,
  input  logic [PW-1:0] cfg_da_delay,
  input  logic [PW-1:0] cfg_acq_delay,
  input  logic [PW-1:0] cfg_ccd_delay,
  input  logic          start,
  input  logic          abort,
  output logic [PW-1:0] da_x,
  output logic [PW-1:0] da_y,
  output logic          da_wr,
  output logic          ccd_trig,
  output logic          acq_en,
  output logic          busy,
  output logic          line_done,
  output logic          scan_done,
  output logic          cfg_err
);

  typedef enum logic [3:0] {
    IDLE, DA_SET, DA_WAIT, CCD_WAIT, TRIG, ACQ_WAIT, DWELL, NEXT, DONE
  } state_t;

  localparam logic [PW-1:0] ONE = PW'(1);

  state_t        state_reg, state_next;
  logic [PW-1:0] x_points_reg, x_blocks_m1_reg, y_points_reg, cpp_reg;
  logic [PW-1:0] da_delay_reg, acq_delay_reg, ccd_delay_reg;
  logic          cfg_loaded_reg;
  logic [PW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] xi_reg, xi_next, bi_reg, bi_next, yi_reg, yi_next;
  logic [PW-1:0] da_x_reg, da_y_reg;
  logic          cfg_err_reg, cfg_err_next;
  logic          cfg_ok;

  assign cfg_ok = cfg_loaded_reg && (x_points_reg != '0) && (y_points_reg != '0)
                  && (cpp_reg != '0);

  // Configuration is only accepted while idle so a running scan never changes shape.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_points_reg    <= '0;
      x_blocks_m1_reg <= '0;
      y_points_reg    <= '0;
      cpp_reg         <= '0;
      da_delay_reg    <= '0;
      acq_delay_reg   <= '0;
      ccd_delay_reg   <= '0;
      cfg_loaded_reg  <= 1'b0;
    end else if (state_reg == IDLE && cfg_valid) begin
      x_points_reg    <= cfg_x_points;
      x_blocks_m1_reg <= (cfg_x_blocks == '0) ? '0 : cfg_x_blocks - ONE;
      y_points_reg    <= cfg_y_points;
      cpp_reg         <= cfg_cycles_per_point;
      da_delay_reg    <= cfg_da_delay;
      acq_delay_reg   <= cfg_acq_delay;
      ccd_delay_reg   <= cfg_ccd_delay;
      cfg_loaded_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      xi_reg      <= '0;
      bi_reg      <= '0;
      yi_reg      <= '0;
      da_x_reg    <= '0;
      da_y_reg    <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      xi_reg      <= xi_next;
      bi_reg      <= bi_next;
      yi_reg      <= yi_next;
      cfg_err_reg <= cfg_err_next;
      if (state_reg == DA_SET) begin
        da_x_reg <= xi_reg;
        da_y_reg <= yi_reg;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    xi_next      = xi_reg;
    bi_next      = bi_reg;
    yi_next      = yi_reg;
    cfg_err_next = 1'b0;
    da_wr        = 1'b0;
    ccd_trig     = 1'b0;
    acq_en       = 1'b0;
    line_done    = 1'b0;
    scan_done    = 1'b0;

    // Every timed phase loads count-1 on entry and leaves when the counter hits zero;
    // zero-length phases are skipped at the point of entry.
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            xi_next    = '0;
            bi_next    = '0;
            yi_next    = '0;
            state_next = DA_SET;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      DA_SET: begin
        da_wr = 1'b1;
        if (da_delay_reg != '0) begin
          state_next = DA_WAIT;
          cnt_next   = da_delay_reg - ONE;
        end else if (ccd_delay_reg != '0) begin
          state_next = CCD_WAIT;
          cnt_next   = ccd_delay_reg - ONE;
        end else begin
          state_next = TRIG;
        end
      end
      DA_WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - ONE;
        end else if (ccd_delay_reg != '0) begin
          state_next = CCD_WAIT;
          cnt_next   = ccd_delay_reg - ONE;
        end else begin
          state_next = TRIG;
        end
      end
      CCD_WAIT: begin
        if (cnt_reg != '0) cnt_next = cnt_reg - ONE;
        else state_next = TRIG;
      end
      TRIG: begin
        ccd_trig = 1'b1;
        if (acq_delay_reg != '0) begin
          state_next = ACQ_WAIT;
          cnt_next   = acq_delay_reg - ONE;
        end else begin
          state_next = DWELL;
          cnt_next   = cpp_reg - ONE;
        end
      end
      ACQ_WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - ONE;
        end else begin
          state_next = DWELL;
          cnt_next   = cpp_reg - ONE;
        end
      end
      DWELL: begin
        acq_en = 1'b1;
        if (cnt_reg != '0) cnt_next = cnt_reg - ONE;
        else state_next = NEXT;
      end
      NEXT: begin
        state_next = DA_SET;
        if (xi_reg == x_points_reg - ONE) begin
          xi_next   = '0;
          line_done = 1'b1;
          if (bi_reg == x_blocks_m1_reg) begin
            bi_next = '0;
            if (yi_reg == y_points_reg - ONE) state_next = DONE;
            else yi_next = yi_reg + ONE;
          end else begin
            bi_next = bi_reg + ONE;
          end
        end else begin
          xi_next = xi_reg + ONE;
        end
      end
      DONE: begin
        scan_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      da_wr      = 1'b0;
      ccd_trig   = 1'b0;
      acq_en     = 1'b0;
      line_done  = 1'b0;
      scan_done  = 1'b0;
    end
  end

  // The new position is presented during DA_SET itself, then held.
  assign da_x    = (state_reg == DA_SET) ? xi_reg : da_x_reg;
  assign da_y    = (state_reg == DA_SET) ? yi_reg : da_y_reg;
  assign busy    = (state_reg != IDLE);
  assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: table of scan configurations with
// hand-computed timing, plus abort, reconfigure-while-busy and reset sequences.
module tb_scan_sequencer;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [PW-1:0] cfg_x_points = '0, cfg_x_blocks = '0, cfg_y_points = '0;
  logic [PW-1:0] cfg_cycles_per_point = '0, cfg_da_delay = '0;
  logic [PW-1:0] cfg_acq_delay = '0, cfg_ccd_delay = '0;
  logic          start = 1'b0, abort = 1'b0;
  logic [PW-1:0] da_x, da_y;
  logic          da_wr, ccd_trig, acq_en, busy, line_done, scan_done, cfg_err;

  always #5 clk = ~clk;

  scan_sequencer #(.PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid),
    .cfg_x_points(cfg_x_points), .cfg_x_blocks(cfg_x_blocks),
    .cfg_y_points(cfg_y_points), .cfg_cycles_per_point(cfg_cycles_per_point),
    .cfg_da_delay(cfg_da_delay), .cfg_acq_delay(cfg_acq_delay),
    .cfg_ccd_delay(cfg_ccd_delay), .start(start), .abort(abort),
    .da_x(da_x), .da_y(da_y), .da_wr(da_wr), .ccd_trig(ccd_trig),
    .acq_en(acq_en), .busy(busy), .line_done(line_done),
    .scan_done(scan_done), .cfg_err(cfg_err)
  );

  // xp,xb,yp,cpp,da,ccd,acq then expected: writes, period, trig offset, acq cycles, lines, busy cycles
  typedef struct {
    int xp, xb, yp, cpp, da, ccd, acq;
    int n_wr, period, trig_off, n_acq, n_line, n_busy;
  } vec_t;

  vec_t vecs [4];
  int   n_checks = 0;
  int   n_fail = 0;

  int   wr_cyc[$], wr_x[$], wr_y[$], trig_cyc[$];
  int   m_acq, m_line, m_done, m_busy;
  logic m_timeout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_cfg(input vec_t v);
    cfg_x_points         = PW'(v.xp);
    cfg_x_blocks         = PW'(v.xb);
    cfg_y_points         = PW'(v.yp);
    cfg_cycles_per_point = PW'(v.cpp);
    cfg_da_delay         = PW'(v.da);
    cfg_ccd_delay        = PW'(v.ccd);
    cfg_acq_delay        = PW'(v.acq);
    cfg_valid            = 1'b1;
    @(negedge clk);
    cfg_valid            = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples every falling edge from the first DA_SET cycle until scan_done.
  task automatic monitor_scan(input int inj_cyc, input int budget);
    wr_cyc.delete(); wr_x.delete(); wr_y.delete(); trig_cyc.delete();
    m_acq = 0; m_line = 0; m_done = 0; m_busy = 0; m_timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (c == inj_cyc) begin
        cfg_valid = 1'b1;
        cfg_cycles_per_point = PW'(9);
        cfg_x_points = PW'(1);
      end
      if (c == inj_cyc + 1) cfg_valid = 1'b0;
      if (da_wr) begin
        wr_cyc.push_back(c); wr_x.push_back(int'(da_x)); wr_y.push_back(int'(da_y));
      end
      if (ccd_trig)  trig_cyc.push_back(c);
      if (acq_en)    m_acq++;
      if (line_done) m_line++;
      if (busy)      m_busy++;
      if (scan_done) begin
        m_done++;
        m_timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_scan(input vec_t v, input string tag);
    int bad, idx, xbe;
    chk({tag, "_timeout"}, m_timeout, 0);
    chk({tag, "_wr_count"}, wr_cyc.size(), v.n_wr);
    chk({tag, "_trig_count"}, trig_cyc.size(), v.n_wr);
    bad = 0;
    for (int i = 1; i < wr_cyc.size(); i++)
      if (wr_cyc[i] - wr_cyc[i-1] != v.period) bad++;
    chk({tag, "_period_errors"}, bad, 0);
    if (wr_cyc.size() > 0 && trig_cyc.size() > 0)
      chk({tag, "_trig_offset"}, trig_cyc[0] - wr_cyc[0], v.trig_off);
    else
      chk({tag, "_trig_present"}, 0, 1);
    chk({tag, "_acq_cycles"}, m_acq, v.n_acq);
    chk({tag, "_line_done"}, m_line, v.n_line);
    chk({tag, "_scan_done"}, m_done, 1);
    chk({tag, "_busy_cycles"}, m_busy, v.n_busy);
    xbe = (v.xb == 0) ? 1 : v.xb;
    bad = 0; idx = 0;
    for (int y = 0; y < v.yp; y++)
      for (int b = 0; b < xbe; b++)
        for (int x = 0; x < v.xp; x++) begin
          if (idx >= wr_x.size()) bad++;
          else if (wr_x[idx] != x || wr_y[idx] != y) bad++;
          idx++;
        end
    chk({tag, "_coord_errors"}, bad, 0);
    @(negedge clk);
    chk({tag, "_idle_after"}, busy, 0);
    $display("scan %s: writes=%0d lines=%0d acq=%0d busy=%0d", tag, wr_cyc.size(),
             m_line, m_acq, m_busy);
  endtask

  initial begin
    int bad;
    logic got;
    vecs[0] = '{3, 1, 2, 4, 2, 1, 3,  6, 13, 4, 24, 2, 79};
    vecs[1] = '{1, 1, 1, 1, 0, 0, 0,  1,  4, 1,  1, 1,  5};
    vecs[2] = '{2, 2, 1, 2, 1, 0, 0,  4,  6, 2,  8, 2, 25};
    vecs[3] = '{2, 0, 2, 1, 0, 2, 1,  4,  7, 3,  4, 2, 29};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {da_x, da_y, da_wr, ccd_trig, acq_en, busy, line_done,
                          scan_done, cfg_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start without any configuration
    do_start();
    chk("nocfg_cfg_err", cfg_err, 1);
    chk("nocfg_busy", busy, 0);
    @(negedge clk);
    chk("nocfg_cfg_err_pulse", cfg_err, 0);
    $display("start without cfg: cfg_err pulsed");

    // Start with y_points = 0
    do_cfg('{2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    do_start();
    chk("ypts0_cfg_err", cfg_err, 1);
    chk("ypts0_busy", busy, 0);
    @(negedge clk);
    chk("ypts0_busy_after", busy, 0);
    $display("start with y_points=0: cfg_err pulsed");

    for (int i = 0; i < 4; i++) begin
      do_cfg(vecs[i]);
      do_start();
      monitor_scan(-1, 2000);
      check_scan(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort in the DWELL phase of the second point
    do_cfg(vecs[0]);
    do_start();
    bad = 0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (da_wr) bad++;
      if (bad >= 2 && acq_en) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reached_dwell", got, 1);
    abort = 1'b1;
    #1;
    chk("abort_acq_same_cycle", acq_en, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_acq_next", acq_en, 0);
    chk("abort_busy_next", busy, 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy || scan_done) bad++;
      @(negedge clk);
    end
    chk("abort_stays_idle", bad, 0);
    $display("abort during dwell: returned to idle");
    do_start();
    monitor_scan(-1, 2000);
    check_scan(vecs[0], "rerun");

    // Reconfigure while busy must not affect the running scan
    do_start();
    monitor_scan(20, 2000);
    check_scan(vecs[0], "cfg_busy");

    // Reset mid-scan clears cfg_loaded
    do_start();
    repeat (10) @(negedge clk);
    chk("midrst_was_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {da_x, da_y, da_wr, ccd_trig, acq_en, busy, line_done,
                           scan_done, cfg_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    chk("postrst_cfg_err", cfg_err, 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy || scan_done) bad++;
      @(negedge clk);
    end
    chk("postrst_start_ignored", bad, 0);
    $display("reset mid-scan: start refused until reconfigured");
    do_cfg(vecs[1]);
    do_start();
    monitor_scan(-1, 2000);
    check_scan(vecs[1], "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter PW, default 16, width of every count, delay and index field.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port cfg_valid  in  1  one-cycle pulse; the cfg_* buses are valid in that cycle.
REQ-005 SHALL have ports cfg_x_points, cfg_x_blocks, cfg_y_points, cfg_cycles_per_point, cfg_da_delay, cfg_acq_delay, cfg_ccd_delay  in  PW each  scan configuration words.
REQ-006 SHALL have port start  in  1  one-cycle scan request.
REQ-007 SHALL have port abort  in  1  one-cycle scan cancel.
REQ-008 SHALL have ports da_x, da_y  out  PW each  galvo position indices.
REQ-009 SHALL have port da_wr  out  1  DAC write strobe.
REQ-010 SHALL have port ccd_trig  out  1  camera trigger pulse.
REQ-011 SHALL have port acq_en  out  1  acquisition window.
REQ-012 SHALL have ports busy, line_done, scan_done, cfg_err  out  1 each  status signals.

Function
REQ-013 SHALL latch all cfg_* words and set the internal cfg_loaded flag on cfg_valid only while in IDLE; cfg_valid in any other state is ignored.
REQ-014 SHALL implement states IDLE, DA_SET, DA_WAIT, CCD_WAIT, TRIG, ACQ_WAIT, DWELL, NEXT, DONE.
REQ-015 SHALL, on start in IDLE with cfg_loaded=1 and x_points, y_points, cycles_per_point all nonzero, zero the indices xi, bi, yi and enter DA_SET on the next edge.
REQ-016 SHALL otherwise pulse cfg_err for 1 cycle on start in IDLE and remain in IDLE; start outside IDLE is ignored.
REQ-017 SHALL treat x_blocks=0 as 1.
REQ-018 SHALL, in DA_SET (1 cycle), drive da_wr=1 with da_x=xi and da_y=yi; da_x/da_y hold their values until the next DA_SET.
REQ-019 SHALL stay in DA_WAIT, CCD_WAIT, ACQ_WAIT and DWELL for exactly da_delay, ccd_delay, acq_delay and cycles_per_point cycles respectively, using one shared PW-bit down-counter.
REQ-020 SHALL skip a phase whose count is 0 and proceed directly to the following state.
REQ-021 SHALL, in TRIG (1 cycle), drive ccd_trig=1.
REQ-022 SHALL drive acq_en=1 in every DWELL cycle and 0 at all other times.
REQ-023 SHALL make the point period exactly 3 + da_delay + ccd_delay + acq_delay + cycles_per_point cycles (DA_SET + TRIG + NEXT + the phases).
REQ-024 SHALL, in NEXT (1 cycle), advance the indices:
- xi increments.
- If xi==x_points-1: xi=0, bi increments, and line_done pulses for 1 cycle.
- If additionally bi==x_blocks-1: bi=0 and yi increments.
- If additionally yi==y_points-1: go to DONE; otherwise go to DA_SET.
REQ-025 SHALL, in DONE (1 cycle), pulse scan_done=1, then return to IDLE; cfg_loaded stays set, so start may rerun the same configuration.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL, on abort in any non-IDLE state, enter IDLE on the next edge with da_wr, ccd_trig, acq_en and line_done forced to 0 in that cycle and scan_done not asserted.
REQ-028 SHALL give abort priority over start, over NEXT progress and over DONE when they coincide.
REQ-029 SHALL handle all counts 1..2^PW-1 exactly, with no index or counter overflow.

Reset
REQ-030 SHALL, while rst_n=0, force the state to IDLE, cfg_loaded=0, all counters and indices to 0, and all outputs to 0.
REQ-031 SHALL, on reset assertion mid-scan, abandon the scan with no scan_done pulse; after reset release a new start requires a new cfg_valid.

Verification
REQ-032 SHALL cover: cfg x_points=3, x_blocks=1, y_points=2, cpp=4, da=2, ccd=1, acq=3, then start -> 6 da_wr pulses 13 cycles apart with (da_x,da_y)=(0,0),(1,0),(2,0),(0,1),(1,1),(2,1); 2 line_done pulses; 1 scan_done pulse.
REQ-033 SHALL cover: da=ccd=acq=0, cpp=1, x_points=1, y_points=1 -> point period 4 cycles, ccd_trig exactly 1 cycle after da_wr, acq_en high 1 cycle, then scan_done.
REQ-034 SHALL cover: x_blocks=2, x_points=2, y_points=1 -> da_x sequence 0,1,0,1 with da_y=0 throughout, line_done twice, scan_done once.
REQ-035 SHALL cover: start with no prior cfg_valid, and separately start after cfg with y_points=0 -> cfg_err pulse each time, busy stays 0.
REQ-036 SHALL cover: abort asserted during DWELL -> acq_en=0 and busy=0 on the next cycle, no scan_done; a subsequent start reruns the scan from (0,0).
REQ-037 SHALL cover: cfg_valid with cpp=9 pulsed while busy -> the running scan keeps its original cpp; rst_n pulsed mid-scan -> all outputs 0 and start ignored until a new cfg_valid.
